// File: rtl/fft_pkg.sv
// Shared definitions for the FFT/IFFT frame sequencer and the stage datapath.
//   fft_state_e     : sequencer state (idle, stage stepping, output window)
//   stage_count     : number of butterfly stages for a transform size
//   dwell_cycles    : cycles spent in stage k, 2^k plus the extra pipeline latency
//   dwell_cnt_width : width of a counter that can hold any stage dwell
package fft_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStage  = 2'd1,
    StOutput = 2'd2
  } fft_state_e;

  function automatic int unsigned stage_count(input int unsigned nfft);
    return $clog2(nfft);
  endfunction

  function automatic int unsigned dwell_cycles(input int unsigned k,
                                               input int unsigned stage_lat);
    return (32'd1 << k) + stage_lat;
  endfunction

  function automatic int unsigned dwell_cnt_width(input int unsigned nfft,
                                                  input int unsigned stage_lat);
    return $clog2(nfft / 2 + stage_lat + 1);
  endfunction

endpackage

// File: rtl/fft_stage_timer.sv
// Dwell counter for one butterfly stage.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : reload the count to zero on the next edge
//   limit    : terminal count (dwell - 1) of the active stage
//   done     : count has reached limit in this cycle
module fft_stage_timer #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [CntW-1:0] limit,
  output logic            done
);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CntW'(1);
    end
  end

  assign done = (count_q == limit);

endmodule

// File: rtl/fft_stage_sequencer.sv
// Frame sequencer for the SDF mixed-radix FFT/IFFT pipeline.
// A accepted start walks a one-hot stage enable through every butterfly stage, each held for
// 2^k + STAGE_LAT cycles, then opens an NFFT-sample output window that out_hold can stall.
//   clk, rst    : clock, asynchronous active-low reset
//   start       : frame request; inverse is latched into mode_inv when it is accepted
//   out_hold    : output backpressure, registered (acts on the following output cycle)
//   start_stage : one-hot active stage, busy : frame in progress
//   end_fft     : first output-window cycle, data_valid/out_index/last_out : output stream
//   start_err   : pulses the cycle after a dropped start
// Build option: define FFT_SEQ_BACK2BACK_EN to queue one start that arrives during the
// output window and launch it directly after last_out.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned NFFT      = 64,
  parameter int unsigned STAGE_LAT = 2,
  localparam int unsigned NSTAGES  = stage_count(NFFT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               inverse,
  input  logic               out_hold,
  output logic [NSTAGES-1:0] start_stage,
  output logic               mode_inv,
  output logic               busy,
  output logic               end_fft,
  output logic               data_valid,
  output logic [NSTAGES-1:0] out_index,
  output logic               last_out,
  output logic               start_err
);

  localparam int unsigned CntW = dwell_cnt_width(NFFT, STAGE_LAT);
  localparam logic [NSTAGES-1:0] LastIdx    = NSTAGES'(NFFT - 1);
  localparam logic [NSTAGES-1:0] FirstStage = NSTAGES'(1);

  fft_state_e         state_q;
  logic [NSTAGES-1:0] start_stage_q;
  logic [NSTAGES-1:0] out_index_q;
  logic               mode_inv_q;
  logic               busy_q;
  logic               end_fft_q;
  logic               data_valid_q;
  logic               last_out_q;
  logic               start_err_q;
`ifdef FFT_SEQ_BACK2BACK_EN
  logic               pend_q;
  logic               pend_inv_q;
`endif

  logic [CntW-1:0]    dwell_limit;
  logic               dwell_done;
  logic               timer_clear;
  logic [NSTAGES-1:0] next_idx;
  logic               next_last;

  // Terminal count of whichever stage is currently enabled.
  always_comb begin
    dwell_limit = '0;
    for (int unsigned k = 0; k < NSTAGES; k++) begin
      if (start_stage_q[k]) begin
        dwell_limit = dwell_limit | CntW'(dwell_cycles(k, STAGE_LAT) - 1);
      end
    end
  end

  // Held at zero outside STAGE so the first stage always starts from a clean count.
  assign timer_clear = (state_q != StStage) || dwell_done;

  fft_stage_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .limit (dwell_limit),
    .done  (dwell_done)
  );

  // Index only moves past samples that were actually presented.
  assign next_idx  = out_index_q + {{(NSTAGES - 1){1'b0}}, data_valid_q};
  assign next_last = ~out_hold && (next_idx == LastIdx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      start_stage_q <= '0;
      out_index_q   <= '0;
      mode_inv_q    <= 1'b0;
      busy_q        <= 1'b0;
      end_fft_q     <= 1'b0;
      data_valid_q  <= 1'b0;
      last_out_q    <= 1'b0;
      start_err_q   <= 1'b0;
`ifdef FFT_SEQ_BACK2BACK_EN
      pend_q        <= 1'b0;
      pend_inv_q    <= 1'b0;
`endif
    end else begin
      end_fft_q   <= 1'b0;
      start_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q       <= StStage;
            start_stage_q <= FirstStage;
            busy_q        <= 1'b1;
            mode_inv_q    <= inverse;
          end
        end
        StStage: begin
          start_err_q <= start;
          if (dwell_done) begin
            if (start_stage_q[NSTAGES-1]) begin
              state_q       <= StOutput;
              start_stage_q <= '0;
              end_fft_q     <= 1'b1;
              data_valid_q  <= ~out_hold;
              out_index_q   <= '0;
              last_out_q    <= 1'b0;
            end else begin
              start_stage_q <= start_stage_q << 1;
            end
          end
        end
        StOutput: begin
`ifdef FFT_SEQ_BACK2BACK_EN
          start_err_q <= start & pend_q;
          if (last_out_q) begin
            data_valid_q <= 1'b0;
            last_out_q   <= 1'b0;
            out_index_q  <= '0;
            pend_q       <= 1'b0;
            // A start on the final output cycle is taken as if it had been queued.
            if (pend_q || start) begin
              state_q       <= StStage;
              start_stage_q <= FirstStage;
              mode_inv_q    <= pend_q ? pend_inv_q : inverse;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            if (start && !pend_q) begin
              pend_q     <= 1'b1;
              pend_inv_q <= inverse;
            end
            data_valid_q <= ~out_hold;
            out_index_q  <= next_idx;
            last_out_q   <= next_last;
          end
`else
          start_err_q <= start;
          if (last_out_q) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            last_out_q   <= 1'b0;
            out_index_q  <= '0;
          end else begin
            data_valid_q <= ~out_hold;
            out_index_q  <= next_idx;
            last_out_q   <= next_last;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign start_stage = start_stage_q;
  assign mode_inv    = mode_inv_q;
  assign busy        = busy_q;
  assign end_fft     = end_fft_q;
  assign data_valid  = data_valid_q;
  assign out_index   = out_index_q;
  assign last_out    = last_out_q;
  assign start_err   = start_err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer at NFFT=8, STAGE_LAT=2.
module tb_fft_stage_sequencer;

  localparam int unsigned NFFT = 8;
  localparam int unsigned LAT  = 2;
  localparam int unsigned NST  = 3;
  localparam int T0 = 1 + (NFFT - 1) + NST * LAT;  // first output cycle of a frame

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic inverse = 1'b0;
  logic out_hold = 1'b0;
  logic [NST-1:0] start_stage;
  logic [NST-1:0] out_index;
  logic mode_inv, busy, end_fft, data_valid, last_out, start_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: frame described by its relative cycle number.
  bit m_active, m_q, m_qinv, m_inv;
  int m_r, m_vcnt;
  logic [NST-1:0] e_stage;
  bit e_ef, e_dv, e_last, e_busy, e_err;
  int e_idx;

  typedef struct {
    int             cyc;
    logic [NST-1:0] stage;
    bit             ef;
    bit             dv;
    int             idx;
    bit             last;
    bit             bsy;
  } vec_t;
  vec_t tbl[11];

  fft_stage_sequencer #(
    .NFFT      (NFFT),
    .STAGE_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .inverse     (inverse),
    .out_hold    (out_hold),
    .start_stage (start_stage),
    .mode_inv    (mode_inv),
    .busy        (busy),
    .end_fft     (end_fft),
    .data_valid  (data_valid),
    .out_index   (out_index),
    .last_out    (last_out),
    .start_err   (start_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int stage_of(input int r);
    int acc;
    acc = 0;
    for (int k = 0; k < int'(NST); k++) begin
      acc += (1 << k) + int'(LAT);
      if (r <= acc) return k;
    end
    return int'(NST) - 1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_q = 0; m_qinv = 0; m_inv = 0; m_r = 0; m_vcnt = 0;
    e_stage = '0; e_ef = 0; e_dv = 0; e_last = 0; e_busy = 0; e_err = 0; e_idx = 0;
  endtask

  // Advance the model across one clock edge with the inputs sampled at that edge.
  task automatic model_step(input bit st, input bit inv, input bit hold);
    bit ended, take, tinv, err;
    ended = e_last;
    take = 0; tinv = 0; err = 0;
    if (e_dv) m_vcnt++;
    if (!m_active) begin
      take = st;
      tinv = inv;
    end else if (m_r < T0) begin
      err = st;
    end else begin
`ifdef FFT_SEQ_BACK2BACK_EN
      if (m_q) err = st;
      else if (st) begin m_q = 1; m_qinv = inv; end
`else
      err = st;
`endif
    end
    if (ended) begin
      m_active = 0;
      if (m_q) begin take = 1; tinv = m_qinv; m_q = 0; end
    end
    if (take) begin
      m_active = 1; m_r = 0; m_inv = tinv; m_vcnt = 0;
    end
    m_r++;
    e_err = err;
    e_stage = '0; e_ef = 0; e_dv = 0; e_last = 0; e_idx = 0; e_busy = m_active;
    if (m_active) begin
      if (m_r < T0) begin
        e_stage = NST'(1 << stage_of(m_r));
      end else begin
        e_ef   = (m_r == T0);
        e_dv   = !hold;
        e_idx  = m_vcnt;
        e_last = e_dv && (m_vcnt == int'(NFFT) - 1);
      end
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({start_stage, mode_inv, busy, end_fft, data_valid, out_index, last_out,
                start_err});
  endfunction

  function automatic logic [31:0] model_vec();
    return 32'({e_stage, m_inv, e_busy, e_ef, e_dv, NST'(e_idx), e_last, e_err});
  endfunction

  // Drive inputs for the next edge, step the model, then compare the whole output set.
  task automatic run_cycle(input bit st, input bit inv, input bit hold);
    start = st; inverse = inv; out_hold = hold;
    model_step(st, inv, hold);
    @(posedge clk);
    #1;
    check("model_outputs", dut_vec(), model_vec());
  endtask

  initial begin
    int c;
    int k;
    tbl[0]  = '{1,  3'b001, 0, 0, 0, 0, 1};
    tbl[1]  = '{3,  3'b001, 0, 0, 0, 0, 1};
    tbl[2]  = '{4,  3'b010, 0, 0, 0, 0, 1};
    tbl[3]  = '{7,  3'b010, 0, 0, 0, 0, 1};
    tbl[4]  = '{8,  3'b100, 0, 0, 0, 0, 1};
    tbl[5]  = '{13, 3'b100, 0, 0, 0, 0, 1};
    tbl[6]  = '{14, 3'b000, 1, 1, 0, 0, 1};
    tbl[7]  = '{15, 3'b000, 0, 1, 1, 0, 1};
    tbl[8]  = '{18, 3'b000, 0, 1, 4, 0, 1};
    tbl[9]  = '{21, 3'b000, 0, 1, 7, 1, 1};
    tbl[10] = '{22, 3'b000, 0, 0, 0, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), 32'd0);
    rst = 1'b1;
    run_cycle(0, 0, 0);

    // Basic timing against the fixed table.
    c = 0;
    for (int i = 0; i < 11; i++) begin
      while (c < tbl[i].cyc) begin
        run_cycle(c == 0, 0, 0);
        c++;
      end
      check($sformatf("basic_cycle%0d", tbl[i].cyc),
            32'({start_stage, end_fft, data_valid, out_index, last_out, busy}),
            32'({tbl[i].stage, tbl[i].ef, tbl[i].dv, NST'(tbl[i].idx), tbl[i].last,
                 tbl[i].bsy}));
    end
    repeat (3) run_cycle(0, 0, 0);

    // Mode latch with inverse toggling; second frame started on the busy-falling cycle.
    for (int e = 0; e < 44; e++) begin
      if (e == 0)       run_cycle(1, 1, 0);
      else if (e == 22) run_cycle(1, 0, 0);
      else              run_cycle(0, e[0], 0);
      if (e + 1 <= 21) check("mode_latch_ifft", 32'(mode_inv), 32'd1);
      if (e + 1 >= 23) check("mode_latch_fft", 32'(mode_inv), 32'd0);
      if (e + 1 == 23) check("restart_on_idle", 32'({start_stage, start_err}), 32'b0010);
    end
    run_cycle(0, 0, 0);

    // Backpressure: out_hold sampled after index 3 freezes index 4 for three cycles.
    for (int e = 0; e < 26; e++) begin
      run_cycle(e == 0, 0, (e >= 17 && e <= 19));
      if (e + 1 >= 18 && e + 1 <= 20)
        check("hold_freeze", 32'({data_valid, out_index}), 32'({1'b0, 3'd4}));
      if (e + 1 == 21) check("hold_resume", 32'({data_valid, out_index}), 32'({1'b1, 3'd4}));
      if (e + 1 == 24) check("hold_last", 32'({last_out, out_index}), 32'({1'b1, 3'd7}));
      if (e + 1 == 25) check("hold_busy_ext", 32'(busy), 32'd0);
    end

    // Overrun in stage 1, then a start at out_index 5.
    for (int e = 0; e < 22; e++) begin
      run_cycle(e == 0 || e == 5 || e == 19, e == 19, 0);
      if (e + 1 == 6) check("overrun_err", 32'(start_err), 32'd1);
      if (e + 1 == 7) check("overrun_err_once", 32'(start_err), 32'd0);
      if (e + 1 == 14) check("overrun_t0", 32'({end_fft, data_valid}), 32'b11);
      if (e + 1 == 21) check("overrun_last", 32'(last_out), 32'd1);
`ifdef FFT_SEQ_BACK2BACK_EN
      if (e + 1 == 20) check("b2b_queue_no_err", 32'(start_err), 32'd0);
      if (e + 1 == 22)
        check("b2b_restart", 32'({busy, start_stage, mode_inv}), 32'({1'b1, 3'b001, 1'b1}));
`else
      if (e + 1 == 20) check("output_start_err", 32'(start_err), 32'd1);
      if (e + 1 == 22) check("overrun_busy_fall", 32'(busy), 32'd0);
`endif
    end
    k = 0;
    while (busy && k < 100) begin
      run_cycle(0, 0, 0);
      k++;
    end
    check("drain_idle", 32'(busy), 32'd0);

    // Reset abort during the output window.
    for (int e = 0; e < 17; e++) run_cycle(e == 0, 1, 0);
    check("abort_pre", 32'({data_valid, out_index}), 32'({1'b1, 3'd3}));
    rst = 1'b0;
    #1;
    check("abort_outputs", dut_vec(), 32'd0);
    @(posedge clk);
    #1;
    check("abort_held", dut_vec(), 32'd0);
    rst = 1'b1;
    model_reset();
    for (int e = 0; e < 22; e++) begin
      run_cycle(e == 0, 0, 0);
      if (e + 1 == 1) check("abort_restart_stage", 32'(start_stage), 32'd1);
      if (e + 1 == 14) check("abort_restart_t0", 32'(end_fft), 32'd1);
      if (e + 1 == 22) check("abort_restart_done", 32'(busy), 32'd0);
    end

    // Randomized traffic against the model.
    for (int e = 0; e < 2000; e++) begin
      run_cycle($urandom_range(0, 15) == 0, 1'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
